// File: rtl/decode_4to16_pkg.sv
// Shared register-index constants for the select/encode block and the register file.
// Also holds the one-hot helper used by the decoder.
package decode_4to16_pkg;

    localparam int REG_IDX_W = 4;
    localparam int NUM_REGS  = 16;

    // One-hot of a register index. A bit is set only when the index compares
    // true, so an unknown index yields all zeros rather than X in simulation.
    function automatic logic [NUM_REGS-1:0] onehot(
        input logic [REG_IDX_W-1:0] idx
    );
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (idx == REG_IDX_W'(n)) begin
                v[n] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/decode_4to16.sv
// 4-to-16 one-hot register-select decoder with a registered debug copy.
// Ports:
//   clk           in   rising edge loads dec_q only
//   clr           in   async active-low reset, clears dec_q only
//   in[3:0]       in   binary register index
//   out0..out15   out  combinational selects, outN = (in == N)
//   dec_q[15:0]   out  one-cycle registered copy, bit N = outN
module decode_4to16
    import decode_4to16_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic [REG_IDX_W-1:0] in,
    // Positional order is relied upon by callers; do not reorder.
    output logic                 out0,
    output logic                 out1,
    output logic                 out10,
    output logic                 out11,
    output logic                 out12,
    output logic                 out13,
    output logic                 out14,
    output logic                 out15,
    output logic                 out2,
    output logic                 out3,
    output logic                 out4,
    output logic                 out5,
    output logic                 out6,
    output logic                 out7,
    output logic                 out8,
    output logic                 out9,
    output logic [NUM_REGS-1:0]  dec_q
);

    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] r_dec_q;

    assign w_dec = onehot(in);

    // Mapping is by bit index, independent of port position.
    assign out0  = w_dec[0];
    assign out1  = w_dec[1];
    assign out2  = w_dec[2];
    assign out3  = w_dec[3];
    assign out4  = w_dec[4];
    assign out5  = w_dec[5];
    assign out6  = w_dec[6];
    assign out7  = w_dec[7];
    assign out8  = w_dec[8];
    assign out9  = w_dec[9];
    assign out10 = w_dec[10];
    assign out11 = w_dec[11];
    assign out12 = w_dec[12];
    assign out13 = w_dec[13];
    assign out14 = w_dec[14];
    assign out15 = w_dec[15];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_dec_q <= '0;
        end else begin
            r_dec_q <= w_dec;
        end
    end

    assign dec_q = r_dec_q;

endmodule

// File: tb/tb_decode_4to16.sv
// Self-checking bench for decode_4to16.
// Registered path is checked through an expected-value queue.
module tb_decode_4to16;

    logic        clk;
    logic        clr;
    logic [3:0]  in;
    logic [15:0] dec_q;
    logic        o0, o1, o2, o3, o4, o5, o6, o7;
    logic        o8, o9, o10, o11, o12, o13, o14, o15;
    logic [15:0] w_out;

    int n_checks;
    int n_fail;
    logic [15:0] sb_q[$];

    decode_4to16 dut (
        .clk  (clk),
        .clr  (clr),
        .in   (in),
        .out0 (o0),
        .out1 (o1),
        .out10(o10),
        .out11(o11),
        .out12(o12),
        .out13(o13),
        .out14(o14),
        .out15(o15),
        .out2 (o2),
        .out3 (o3),
        .out4 (o4),
        .out5 (o5),
        .out6 (o6),
        .out7 (o7),
        .out8 (o8),
        .out9 (o9),
        .dec_q(dec_q)
    );

    assign w_out = {o15, o14, o13, o12, o11, o10, o9, o8,
                    o7, o6, o5, o4, o3, o2, o1, o0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [3:0] v);
        logic [15:0] one;
        one = 16'h0001;
        return one << v;
    endfunction

    task automatic test_reset();
        clr = 1'b0;
        in  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dec_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_dec_q got=%h exp=%h", dec_q, 16'h0000);
        end
        n_checks++;
        if (w_out !== 16'h0001) begin
            n_fail++;
            $display("FAIL reset_out got=%h exp=%h", w_out, 16'h0001);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 16; v++) begin
            in = v[3:0];
            #1;
            n_checks++;
            if (w_out !== model(v[3:0])) begin
                n_fail++;
                $display("FAIL sweep_%0d got=%h exp=%h", v, w_out, model(v[3:0]));
            end
            n_checks++;
            if ($countones(w_out) !== 1) begin
                n_fail++;
                $display("FAIL popcount_%0d got=%0d exp=1", v, $countones(w_out));
            end
        end
    endtask

    task automatic test_positional();
        in = 4'd2;
        #1;
        n_checks++;
        if (o2 !== 1'b1 || w_out !== 16'h0004) begin
            n_fail++;
            $display("FAIL pos_out2 got=%b/%h exp=1/0004", o2, w_out);
        end
        in = 4'd10;
        #1;
        n_checks++;
        if (o10 !== 1'b1 || w_out !== 16'h0400) begin
            n_fail++;
            $display("FAIL pos_out10 got=%b/%h exp=1/0400", o10, w_out);
        end
    endtask

    task automatic test_zero_latency();
        @(posedge clk);
        #1;
        in = 4'd5;
        #1;
        n_checks++;
        if (w_out !== 16'h0020) begin
            n_fail++;
            $display("FAIL zero_lat_5 got=%h exp=0020", w_out);
        end
        in = 4'd12;
        #1;
        n_checks++;
        if (w_out !== 16'h1000) begin
            n_fail++;
            $display("FAIL zero_lat_12 got=%h exp=1000", w_out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        clr = 1'b1;
        in  = 4'd7;
        @(posedge clk);
        #1;
        n_checks++;
        if (dec_q !== 16'h0080) begin
            n_fail++;
            $display("FAIL pre_clr_dec_q got=%h exp=0080", dec_q);
        end
        #1;
        clr = 1'b0;
        #1;
        n_checks++;
        if (dec_q !== 16'h0000) begin
            n_fail++;
            $display("FAIL async_clr got=%h exp=0000", dec_q);
        end
        n_checks++;
        if (o7 !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_out7 got=%b exp=1", o7);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (dec_q !== 16'h0000 || o7 !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_hold got=%h/%b exp=0000/1", dec_q, o7);
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        clr = 1'b1;
        in  = 4'd15;
        @(posedge clk);
        #1;
        n_checks++;
        if (dec_q !== 16'h8000) begin
            n_fail++;
            $display("FAIL release_15 got=%h exp=8000", dec_q);
        end
        @(negedge clk);
        in = 4'd0;
        @(posedge clk);
        #1;
        n_checks++;
        if (dec_q !== 16'h0001) begin
            n_fail++;
            $display("FAIL release_0 got=%h exp=0001", dec_q);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        int errs;
        errs = 0;
        sb_q.delete();
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            in = 4'($urandom_range(0, 15));
            sb_q.push_back(model(in));
            #1;
            n_checks++;
            if (w_out !== model(in)) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL rand_out got=%h exp=%h", w_out, model(in));
            end
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_sb_empty got=0 exp=1");
            end else begin
                exp = sb_q.pop_front();
                n_checks++;
                if (dec_q !== exp) begin
                    n_fail++;
                    errs++;
                    if (errs < 10)
                        $display("FAIL rand_dec_q got=%h exp=%h", dec_q, exp);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b0;
        in       = 4'd0;
        test_reset();
        test_sweep();
        test_positional();
        test_zero_latency();
        test_async_reset();
        test_release();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
